// File: rtl/iob_eth_rx.sv
// rtl/iob_eth_rx.sv - MII receive engine: preamble strip, byte assembly, buffer write, FCS check
// Bytes are built low nibble first; a 4-byte delay line keeps the trailing FCS out of the CRC.

module iob_eth_crc (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        data_en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // Non-reflected register fed LSB first; the FCS is the bit-reversed complement of it.
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in;
    for (int i = 0; i < 8; i++) begin
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? 32'h04C1_1DB7 : 32'h0000_0000);
    end
    return c;
  endfunction

  always_comb begin
    crc_d = crc_q;
    if (start) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (data_en) begin
      crc_d = crc_byte(crc_q, data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      crc_q <= 32'hFFFF_FFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

module iob_eth_rx #(
  parameter int BUF_AW = 11
) (
  input  logic              RX_CLK,
  input  logic              rst_n,
  input  logic              RX_DV,
  input  logic [3:0]        RX_DATA,
  input  logic              rcv_ack,
  output logic              wr,
  output logic [BUF_AW-1:0] addr,
  output logic [7:0]        wdata,
  output logic              ready,
  output logic [BUF_AW-1:0] nbytes,
  output logic              crc_err,
  output logic              len_err
);

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    ENDF,
    CHECK,
    DONE,
    WAITIDLE
  } state_t;

  localparam logic [BUF_AW:0]   FULL  = {1'b1, {BUF_AW{1'b0}}};
  localparam logic [BUF_AW:0]   CNT1  = {{BUF_AW{1'b0}}, 1'b1};
  localparam logic [BUF_AW:0]   CNT4  = (BUF_AW+1)'(4);
  localparam logic [BUF_AW:0]   CNT5  = (BUF_AW+1)'(5);
  localparam logic [BUF_AW-1:0] ADDR1 = {{(BUF_AW-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [3:0]        lo_q, lo_d;
  logic [BUF_AW:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       dl_q, dl_d;
  logic              wr_q, wr_d;
  logic [BUF_AW-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic [BUF_AW-1:0] nbytes_q, nbytes_d;
  logic              crc_err_q, crc_err_d;
  logic              len_err_q, len_err_d;
  logic              crc_en_q, crc_en_d;
  logic [7:0]        crc_dat_q, crc_dat_d;

  logic [7:0]        rx_byte;
  logic              crc_start;
  logic [31:0]       crc_val;
  logic [31:0]       fcs_exp;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    return {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]};
  endfunction

  assign rx_byte   = {RX_DATA, lo_q};
  assign crc_start = (state_q == PRE);
  // First received FCS byte sits in dl_q[31:24] and pairs with the top byte here.
  assign fcs_exp   = ~{rev8(crc_val[31:24]), rev8(crc_val[23:16]),
                       rev8(crc_val[15:8]),  rev8(crc_val[7:0])};

  iob_eth_crc u_crc (
    .clk     (RX_CLK),
    .rst_n   (rst_n),
    .start   (crc_start),
    .data_en (crc_en_q),
    .data    (crc_dat_q),
    .crc     (crc_val)
  );

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    dl_d      = dl_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    ready_d   = ready_q;
    nbytes_d  = nbytes_q;
    crc_err_d = crc_err_q;
    len_err_d = len_err_q;
    crc_en_d  = 1'b0;
    crc_dat_d = crc_dat_q;

    // cnt_q already includes the byte just written, so a full buffer freezes addr.
    if (wr_q && (cnt_q != FULL)) begin
      addr_d = addr_q + ADDR1;
    end

    case (state_q)
      IDLE: begin
        if (RX_DV && (RX_DATA == 4'h5)) begin
          state_d = PRE;
        end
      end
      PRE: begin
        if (RX_DV && (RX_DATA == 4'h5)) begin
          state_d = PRE;
        end else if (RX_DV && (RX_DATA == 4'hD)) begin
          state_d = DATA;
          phase_d = 1'b0;
          addr_d  = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          dl_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!RX_DV) begin
          state_d = ENDF;
        end else if (!phase_q) begin
          lo_d    = RX_DATA;
          phase_d = 1'b1;
        end else begin
          phase_d   = 1'b0;
          dl_d      = {dl_q[23:0], rx_byte};
          crc_en_d  = (cnt_q >= CNT4);
          crc_dat_d = dl_q[31:24];
          if (cnt_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_d    = 1'b1;
            wdata_d = rx_byte;
            cnt_d   = cnt_q + CNT1;
          end
        end
      end
      ENDF: begin
        // Settle cycle: the last CRC feed lands before the comparison.
        state_d = CHECK;
      end
      CHECK: begin
        nbytes_d  = (cnt_q == FULL) ? {BUF_AW{1'b1}} : cnt_q[BUF_AW-1:0];
        len_err_d = phase_q | (cnt_q < CNT5) | ovf_q;
        crc_err_d = (cnt_q >= CNT5) && (dl_q != fcs_exp);
        ready_d   = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        if (rcv_ack) begin
          ready_d = 1'b0;
          addr_d  = '0;
          state_d = WAITIDLE;
        end
      end
      WAITIDLE: begin
        if (!RX_DV) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge RX_CLK) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      lo_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      dl_q      <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ready_q   <= 1'b0;
      nbytes_q  <= '0;
      crc_err_q <= 1'b0;
      len_err_q <= 1'b0;
      crc_en_q  <= 1'b0;
      crc_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      lo_q      <= lo_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      dl_q      <= dl_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ready_q   <= ready_d;
      nbytes_q  <= nbytes_d;
      crc_err_q <= crc_err_d;
      len_err_q <= len_err_d;
      crc_en_q  <= crc_en_d;
      crc_dat_q <= crc_dat_d;
    end
  end

  assign wr      = wr_q;
  assign addr    = addr_q;
  assign wdata   = wdata_q;
  assign ready   = ready_q;
  assign nbytes  = nbytes_q;
  assign crc_err = crc_err_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_iob_eth_rx.sv
// tb/tb_iob_eth_rx.sv - frame-level bench for iob_eth_rx with write scoreboard
// Two instances share stimulus: BUF_AW=11 for normal frames and BUF_AW=6 for overflow.

module tb_iob_eth_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_dv;
  logic [3:0]  rx_data;
  logic        rcv_ack;

  logic        wr0, ready0, crc_err0, len_err0;
  logic [10:0] addr0, nbytes0;
  logic [7:0]  wdata0;
  logic        wr1, ready1, crc_err1, len_err1;
  logic [5:0]  addr1, nbytes1;
  logic [7:0]  wdata1;

  always #5 clk = ~clk;

  iob_eth_rx #(.BUF_AW(11)) dut0 (
    .RX_CLK(clk), .rst_n(rst_n), .RX_DV(rx_dv), .RX_DATA(rx_data), .rcv_ack(rcv_ack),
    .wr(wr0), .addr(addr0), .wdata(wdata0), .ready(ready0), .nbytes(nbytes0),
    .crc_err(crc_err0), .len_err(len_err0)
  );

  iob_eth_rx #(.BUF_AW(6)) dut1 (
    .RX_CLK(clk), .rst_n(rst_n), .RX_DV(rx_dv), .RX_DATA(rx_data), .rcv_ack(rcv_ack),
    .wr(wr1), .addr(addr1), .wdata(wdata1), .ready(ready1), .nbytes(nbytes1),
    .crc_err(crc_err1), .len_err(len_err1)
  );

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int n;
    bit corrupt;
    bit odd;
    int exp_nb;
    bit exp_crc;
    bit exp_len;
    bit chk_crc;
  } vec_t;

  int   n_vec = 0;
  int   n_err = 0;
  wr_t  q0[$];
  wr_t  q1[$];
  logic [7:0] frame [0:127];
  vec_t vecs [0:6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_write(input int idx, input logic w, input logic [10:0] a, input logic [7:0] d);
    wr_t e;
    if (w) begin
      n_vec++;
      if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
        n_err++;
        $display("FAIL wr%0d_unexpected: got write addr %0d data %0h, expected no write", idx, a, d);
      end else begin
        e = (idx == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("wr%0d_addr", idx), 32'(a), 32'(e.addr));
        chk($sformatf("wr%0d_data", idx), 32'(d), 32'(e.data));
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon_write(0, wr0, addr0, wdata0);
    mon_write(1, wr1, 11'(addr1), wdata1);
  endtask

  task automatic drive_nib(input logic dv, input logic [3:0] d);
    rx_dv   = dv;
    rx_data = d;
    tick();
  endtask

  function automatic logic [31:0] crc32_ref(input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'h0, frame[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic build_frame(input int n, input bit corrupt);
    logic [31:0] fcs;
    for (int i = 0; i < n; i++) frame[i] = 8'($urandom);
    if (n >= 5) begin
      fcs = crc32_ref(n - 4);
      frame[n-4] = fcs[7:0];
      frame[n-3] = fcs[15:8];
      frame[n-2] = fcs[23:16];
      frame[n-1] = fcs[31:24];
    end
    if (corrupt) frame[10][0] = ~frame[10][0];
  endtask

  task automatic preamble();
    for (int i = 0; i < 15; i++) drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'hD);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit push, input int idx);
    if (push) begin
      q0.push_back('{11'(idx), b});
      if (idx < 64) q1.push_back('{11'(idx), b});
    end
    drive_nib(1'b1, b[3:0]);
    drive_nib(1'b1, b[7:4]);
  endtask

  task automatic idle(input int n);
    rx_dv   = 1'b0;
    rx_data = 4'h0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_ack();
    rcv_ack = 1'b1;
    tick();
    rcv_ack = 1'b0;
    chk("ready_after_ack", 32'(ready0), 32'd0);
    idle(2);
  endtask

  task automatic run_vec(input vec_t v, input bit ack);
    build_frame(v.n, v.corrupt);
    preamble();
    for (int i = 0; i < v.n; i++) send_byte(frame[i], 1'b1, i);
    if (v.odd) drive_nib(1'b1, 4'h9);
    rx_dv   = 1'b0;
    rx_data = 4'h0;
    tick();
    tick();
    chk($sformatf("ready_e1_n%0d", v.n), 32'(ready0), 32'd0);
    tick();
    chk($sformatf("ready_e2_n%0d", v.n), 32'(ready0), 32'd1);
    chk($sformatf("nbytes_n%0d", v.n), 32'(nbytes0), 32'(v.exp_nb));
    chk($sformatf("len_err_n%0d", v.n), 32'(len_err0), 32'(v.exp_len));
    if (v.chk_crc) chk($sformatf("crc_err_n%0d", v.n), 32'(crc_err0), 32'(v.exp_crc));
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    if (ack) do_ack();
  endtask

  initial begin
    vecs[0] = '{64, 1'b0, 1'b0, 64, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{64, 1'b1, 1'b0, 64, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{63, 1'b0, 1'b1, 63, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{3,  1'b0, 1'b0, 3,  1'b0, 1'b1, 1'b1};
    vecs[4] = '{4,  1'b0, 1'b0, 4,  1'b0, 1'b1, 1'b1};
    vecs[5] = '{5,  1'b0, 1'b0, 5,  1'b0, 1'b0, 1'b1};
    vecs[6] = '{20, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b1};

    rst_n   = 1'b0;
    rx_dv   = 1'b0;
    rx_data = 4'h0;
    rcv_ack = 1'b0;
    tick();
    tick();
    chk("rst_wr", 32'(wr0), 32'd0);
    chk("rst_addr", 32'(addr0), 32'd0);
    chk("rst_wdata", 32'(wdata0), 32'd0);
    chk("rst_ready", 32'(ready0), 32'd0);
    chk("rst_nbytes", 32'(nbytes0), 32'd0);
    chk("rst_crc_err", 32'(crc_err0), 32'd0);
    chk("rst_len_err", 32'(len_err0), 32'd0);
    rst_n = 1'b1;
    idle(2);

    for (int k = 0; k < 7; k++) run_vec(vecs[k], 1'b1);

    // Preamble broken by a non-5 nibble, followed by a normal frame.
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'h5);
    drive_nib(1'b1, 4'h3);
    drive_nib(1'b1, 4'hD);
    drive_nib(1'b1, 4'h1);
    drive_nib(1'b1, 4'h2);
    idle(3);
    chk("abort_ready", 32'(ready0), 32'd0);
    run_vec(vecs[0], 1'b1);

    // Frame arriving while ready is held must not disturb the result.
    run_vec(vecs[1], 1'b0);
    build_frame(3, 1'b0);
    preamble();
    for (int i = 0; i < 3; i++) send_byte(frame[i], 1'b0, i);
    idle(4);
    chk("hold_ready", 32'(ready0), 32'd1);
    chk("hold_nbytes", 32'(nbytes0), 32'd64);
    chk("hold_crc_err", 32'(crc_err0), 32'd1);
    chk("hold_len_err", 32'(len_err0), 32'd0);

    // Ack in the middle of an ignored frame: its tail must stay ignored.
    build_frame(30, 1'b0);
    preamble();
    for (int i = 0; i < 30; i++) begin
      if (i == 8) begin
        rcv_ack = 1'b1;
        drive_nib(1'b1, frame[i][3:0]);
        rcv_ack = 1'b0;
        drive_nib(1'b1, frame[i][7:4]);
      end else begin
        send_byte(frame[i], 1'b0, i);
      end
    end
    idle(3);
    chk("midack_ready", 32'(ready0), 32'd0);
    run_vec(vecs[6], 1'b1);

    // Reset in the middle of DATA.
    build_frame(30, 1'b0);
    preamble();
    for (int i = 0; i < 10; i++) send_byte(frame[i], 1'b1, i);
    rst_n = 1'b0;
    drive_nib(1'b1, 4'h0);
    rst_n = 1'b1;
    chk("mid_rst_wr", 32'(wr0), 32'd0);
    chk("mid_rst_addr", 32'(addr0), 32'd0);
    chk("mid_rst_wdata", 32'(wdata0), 32'd0);
    chk("mid_rst_ready", 32'(ready0), 32'd0);
    chk("mid_rst_nbytes", 32'(nbytes0), 32'd0);
    chk("mid_rst_crc_err", 32'(crc_err0), 32'd0);
    chk("mid_rst_len_err", 32'(len_err0), 32'd0);
    for (int i = 0; i < 20; i++) drive_nib(1'b1, 4'h0);
    idle(4);
    chk("mid_rst_q0", 32'(q0.size()), 32'd0);
    chk("mid_rst_ready_after", 32'(ready0), 32'd0);

    // 100-byte frame: normal for BUF_AW=11, overflow for BUF_AW=6.
    build_frame(100, 1'b0);
    preamble();
    for (int i = 0; i < 100; i++) send_byte(frame[i], 1'b1, i);
    idle(3);
    chk("ovf_ready0", 32'(ready0), 32'd1);
    chk("ovf_nbytes0", 32'(nbytes0), 32'd100);
    chk("ovf_crc_err0", 32'(crc_err0), 32'd0);
    chk("ovf_len_err0", 32'(len_err0), 32'd0);
    chk("ovf_ready1", 32'(ready1), 32'd1);
    chk("ovf_nbytes1", 32'(nbytes1), 32'd63);
    chk("ovf_len_err1", 32'(len_err1), 32'd1);
    chk("ovf_addr1", 32'(addr1), 32'd63);
    chk("ovf_q0", 32'(q0.size()), 32'd0);
    chk("ovf_q1", 32'(q1.size()), 32'd0);
    do_ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
